// File: rtl/mii_frame_checker.sv
// mii_frame_checker: parses a byte-wide MII-style stream
// (START, preamble, SFD, payload, TERMINATE) and validates every field.
// It forwards payload bytes, gives a single ok/error report per frame,
// and keeps saturating good and bad frame counters.
// Optional feature: define MII_CHK_FCS_EN to check the CRC-32 FCS at TERMINATE.
module mii_frame_checker #(
  parameter int unsigned PREAMBLE_CYCLES = 6,
  parameter int unsigned MIN_DATA_CYCLES = 46,
  parameter int unsigned MAX_DATA_CYCLES = 1500,
  parameter int unsigned CNT_WIDTH       = 16,
  parameter logic [7:0]  IDLE_CODE       = 8'h07,
  parameter logic [7:0]  START_CODE      = 8'hFB,
  parameter logic [7:0]  PREAMBLE_CODE   = 8'h55,
  parameter logic [7:0]  SFD_CODE        = 8'hD5,
  parameter logic [7:0]  TERMINATE_CODE  = 8'hFD
) (
  input  logic                 clk,
  input  logic                 i_rst,
  input  logic [7:0]           i_rx_data,
  input  logic [7:0]           i_rx_ctrl,
  output logic [7:0]           o_data,
  output logic                 o_data_valid,
  output logic                 o_sof,
  output logic                 o_eof,
  output logic                 o_frame_ok,
  output logic                 o_frame_err,
  output logic [2:0]           o_err_code,
  output logic [CNT_WIDTH-1:0] o_good_cnt,
  output logic [CNT_WIDTH-1:0] o_bad_cnt
);

  localparam int unsigned PW = $clog2(PREAMBLE_CYCLES + 1);
  localparam int unsigned LW = $clog2(MAX_DATA_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_SFD,
    S_DATA,
    S_DROP
  } state_t;

  state_t        state, state_n;
  logic [PW-1:0] pre_cnt, pre_cnt_n;
  logic [LW-1:0] len, len_n;

  logic [7:0]    data_n;
  logic          valid_n, sof_n, ok_n, err_n;
  logic [2:0]    code_n;
  logic          fcs_bad;

  logic is_ctl, ctl_start, ctl_term, ctl_idle, dat_pre, dat_sfd;

  assign is_ctl    = |i_rx_ctrl;
  assign ctl_start = is_ctl  && (i_rx_data == START_CODE);
  assign ctl_term  = is_ctl  && (i_rx_data == TERMINATE_CODE);
  assign ctl_idle  = is_ctl  && (i_rx_data == IDLE_CODE);
  assign dat_pre   = !is_ctl && (i_rx_data == PREAMBLE_CODE);
  assign dat_sfd   = !is_ctl && (i_rx_data == SFD_CODE);

`ifdef MII_CHK_FCS_EN
  logic [31:0] crc, crc_rev;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int unsigned i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  // CRC over the forwarded payload, restarted when a frame enters DATA
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      crc <= '1;
    end else if (state_n == S_DATA && state != S_DATA) begin
      crc <= '1;
    end else if (valid_n) begin
      crc <= crc_byte(crc, i_rx_data);
    end
  end

  // The reflected register holds the residue bit-reversed (0xDEBB20E3),
  // so reverse it to compare against the conventional 0xC704DD7B form
  always_comb begin
    crc_rev = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      crc_rev[i] = crc[31-i];
    end
  end

  assign fcs_bad = (crc_rev != 32'hC704_DD7B);
`else
  assign fcs_bad = 1'b0;
`endif

  // Next-state, byte counters and registered-output values for this byte
  always_comb begin
    state_n   = state;
    pre_cnt_n = pre_cnt;
    len_n     = len;
    data_n    = o_data;
    valid_n   = 1'b0;
    sof_n     = 1'b0;
    ok_n      = 1'b0;
    err_n     = 1'b0;
    code_n    = o_err_code;

    if (ctl_start && state != S_IDLE) begin
      // START outside IDLE restarts the parse; only a live frame is reported
      if (state != S_DROP) begin
        err_n  = 1'b1;
        code_n = 3'd7;
      end
      state_n   = S_PRE;
      pre_cnt_n = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ctl_start) begin
            state_n   = S_PRE;
            pre_cnt_n = '0;
          end
        end
        S_PRE: begin
          if (dat_pre) begin
            if (pre_cnt == PW'(PREAMBLE_CYCLES - 1)) state_n = S_SFD;
            else pre_cnt_n = pre_cnt + PW'(1);
          end else begin
            err_n   = 1'b1;
            code_n  = 3'd1;
            state_n = S_DROP;
          end
        end
        S_SFD: begin
          if (dat_sfd) begin
            state_n = S_DATA;
            len_n   = '0;
          end else begin
            err_n   = 1'b1;
            code_n  = 3'd2;
            state_n = S_DROP;
          end
        end
        S_DATA: begin
          if (!is_ctl) begin
            if (len == LW'(MAX_DATA_CYCLES)) begin
              err_n   = 1'b1;
              code_n  = 3'd4;
              state_n = S_DROP;
            end else begin
              valid_n = 1'b1;
              sof_n   = (len == '0);
              data_n  = i_rx_data;
              len_n   = len + LW'(1);
            end
          end else if (ctl_term) begin
            if (len < LW'(MIN_DATA_CYCLES)) begin
              err_n  = 1'b1;
              code_n = 3'd3;
            end else if (fcs_bad) begin
              err_n  = 1'b1;
              code_n = 3'd6;
            end else begin
              ok_n = 1'b1;
            end
            state_n = S_IDLE;
          end else begin
            err_n   = 1'b1;
            code_n  = 3'd5;
            state_n = S_DROP;
          end
        end
        S_DROP: begin
          if (ctl_idle) state_n = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // State, counters and all outputs registered one cycle after the input byte
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= S_IDLE;
      pre_cnt      <= '0;
      len          <= '0;
      o_data       <= '0;
      o_data_valid <= 1'b0;
      o_sof        <= 1'b0;
      o_eof        <= 1'b0;
      o_frame_ok   <= 1'b0;
      o_frame_err  <= 1'b0;
      o_err_code   <= '0;
      o_good_cnt   <= '0;
      o_bad_cnt    <= '0;
    end else begin
      state        <= state_n;
      pre_cnt      <= pre_cnt_n;
      len          <= len_n;
      o_data       <= data_n;
      o_data_valid <= valid_n;
      o_sof        <= sof_n;
      o_eof        <= ok_n | err_n;
      o_frame_ok   <= ok_n;
      o_frame_err  <= err_n;
      o_err_code   <= code_n;
      if (ok_n && o_good_cnt != '1) o_good_cnt <= o_good_cnt + CNT_WIDTH'(1);
      if (err_n && o_bad_cnt != '1) o_bad_cnt <= o_bad_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_mii_frame_checker.sv
// Directed and randomized bench for mii_frame_checker. Frames are built as
// byte queues and the expected forwarding/report of each byte is derived from
// the frame's shape (lengths, fault position, FCS value). A second instance
// with 2-bit counters sees the same stream to exercise saturation.
module tb_mii_frame_checker;

  localparam int MINLEN = 46;
  localparam int MAXLEN = 1500;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data, rx_ctrl;

  logic [7:0]  o_data;
  logic        o_data_valid, o_sof, o_eof, o_frame_ok, o_frame_err;
  logic [2:0]  o_err_code;
  logic [15:0] o_good_cnt, o_bad_cnt;

  logic [7:0]  s_data;
  logic        s_data_valid, s_sof, s_eof, s_frame_ok, s_frame_err;
  logic [2:0]  s_err_code;
  logic [1:0]  s_good_cnt, s_bad_cnt;

  int         checks = 0;
  int         failures = 0;
  int         good_n = 0;
  int         bad_n = 0;
  logic [2:0] last_code = 3'd0;

  always #5 clk = ~clk;

  mii_frame_checker dut (
    .clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_ctrl(rx_ctrl),
    .o_data(o_data), .o_data_valid(o_data_valid), .o_sof(o_sof), .o_eof(o_eof),
    .o_frame_ok(o_frame_ok), .o_frame_err(o_frame_err), .o_err_code(o_err_code),
    .o_good_cnt(o_good_cnt), .o_bad_cnt(o_bad_cnt)
  );

  mii_frame_checker #(.CNT_WIDTH(2)) dut_sat (
    .clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_ctrl(rx_ctrl),
    .o_data(s_data), .o_data_valid(s_data_valid), .o_sof(s_sof), .o_eof(s_eof),
    .o_frame_ok(s_frame_ok), .o_frame_err(s_frame_err), .o_err_code(s_err_code),
    .o_good_cnt(s_good_cnt), .o_bad_cnt(s_bad_cnt)
  );

  function automatic int sat(input int n, input int mx);
    return (n > mx) ? mx : n;
  endfunction

  // Standard Ethernet CRC-32 (LSB-first, init all-ones, final inversion)
  function automatic logic [31:0] crc32(input byte unsigned q[$], input int n);
    logic [31:0] c;
    logic [7:0]  b;
    logic        fb;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      b = q[i];
      for (int j = 0; j < 8; j++) begin
        fb = c[0] ^ b[j];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB8_8320;
      end
    end
    return ~c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one byte, then check every output for the response to it
  task automatic send(input logic c, input logic [7:0] d, input logic ev, input logic [7:0] ed,
                      input logic es, input logic eok, input logic eerr, input logic [2:0] ecode);
    rx_ctrl = c ? 8'($urandom_range(1, 255)) : 8'h00;
    rx_data = d;
    @(posedge clk);
    #1;
    if (eok) good_n++;
    if (eerr) begin
      bad_n++;
      last_code = ecode;
    end
    chk("data_valid", o_data_valid, ev);
    if (ev) chk("data", o_data, ed);
    chk("sof", o_sof, es);
    chk("eof", o_eof, eok | eerr);
    chk("frame_ok", o_frame_ok, eok);
    chk("frame_err", o_frame_err, eerr);
    chk("err_code", o_err_code, last_code);
    chk("good_cnt", o_good_cnt, sat(good_n, 65535));
    chk("bad_cnt", o_bad_cnt, sat(bad_n, 65535));
    chk("good_cnt_sat", s_good_cnt, sat(good_n, 3));
    chk("bad_cnt_sat", s_bad_cnt, sat(bad_n, 3));
  endtask

  task automatic quiet(input logic c, input logic [7:0] d);
    send(c, d, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0);
  endtask

  // One frame of len payload bytes (FCS included when the FCS check is built).
  // bad_pre: preamble index replaced by 0x54; abort_at: payload index at which
  // the task stops so the caller can inject a fault byte.
  task automatic frame(input int len, input int bad_pre, input int abort_at,
                       input bit seq, input bit flip, input bit skip_start);
    byte unsigned pl[$];
    int           body;
    bit           fcs_ok;
    logic [31:0]  fcs;
    logic [31:0]  rx_fcs;
    bit           ok;
    logic [2:0]   code;
    if (!skip_start) quiet(1'b1, 8'hFB);
    for (int p = 0; p < 6; p++) begin
      if (p == bad_pre) begin
        send(1'b0, 8'h54, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd1);
        return;
      end
      quiet(1'b0, 8'h55);
    end
    quiet(1'b0, 8'hD5);
    body = len;
    fcs_ok = 1'b1;
`ifdef MII_CHK_FCS_EN
    body = len - 4;
`endif
    for (int k = 0; k < body; k++) pl.push_back(seq ? 8'(k) : 8'($urandom));
`ifdef MII_CHK_FCS_EN
    fcs = crc32(pl, body);
    for (int b = 0; b < 4; b++) pl.push_back(fcs[8*b +: 8]);
    if (flip) pl[body + 1] = pl[body + 1] ^ 8'h10;
    rx_fcs = {pl[body+3], pl[body+2], pl[body+1], pl[body]};
    fcs_ok = (rx_fcs == fcs);
`else
    fcs = 32'h0;
    rx_fcs = {31'h0, flip};
`endif
    for (int k = 0; k < pl.size(); k++) begin
      if (k == abort_at) return;
      if (k == MAXLEN) begin
        send(1'b0, pl[k], 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd4);
        return;
      end
      send(1'b0, pl[k], 1'b1, pl[k], k == 0, 1'b0, 1'b0, 3'd0);
    end
    if (len < MINLEN) begin
      ok = 1'b0; code = 3'd3;
    end else if (!fcs_ok) begin
      ok = 1'b0; code = 3'd6;
    end else begin
      ok = 1'b1; code = 3'd0;
    end
    send(1'b1, 8'hFD, 1'b0, 8'h00, 1'b0, ok, !ok, code);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, o_data_valid, 1'b0);
    chk({tag, "_data"}, o_data, 8'h00);
    chk({tag, "_sof"}, o_sof, 1'b0);
    chk({tag, "_eof"}, o_eof, 1'b0);
    chk({tag, "_ok"}, o_frame_ok, 1'b0);
    chk({tag, "_err"}, o_frame_err, 1'b0);
    chk({tag, "_code"}, o_err_code, 3'd0);
    chk({tag, "_good"}, o_good_cnt, 16'd0);
    chk({tag, "_bad"}, o_bad_cnt, 16'd0);
  endtask

  initial begin
    rst = 1'b1;
    rx_ctrl = 8'h01;
    rx_data = 8'h07;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // Idle traffic and non-START bytes produce nothing
    repeat (12) quiet(1'b1, 8'h07);
    quiet(1'b0, 8'hFB);
    quiet(1'b1, 8'h55);
    quiet(1'b0, 8'hFD);

    // Normal frame, payload 0..45
    frame(46, -1, -1, 1'b1, 1'b0, 1'b0);
    quiet(1'b1, 8'h07);

    // Bad 3rd preamble byte, then a good frame
    frame(60, 2, -1, 1'b0, 1'b0, 1'b0);
    quiet(1'b0, 8'h55);
    quiet(1'b1, 8'h07);
    frame(60, -1, -1, 1'b0, 1'b0, 1'b0);

    // Short and length boundaries
    frame(45, -1, -1, 1'b0, 1'b0, 1'b0);
    frame(1501, -1, -1, 1'b0, 1'b0, 1'b0);
    repeat (3) quiet(1'b0, 8'($urandom));
    quiet(1'b1, 8'hFD);
    quiet(1'b1, 8'h07);
    frame(MAXLEN, -1, -1, 1'b0, 1'b0, 1'b0);

    // START at payload byte 20 aborts; the restarted frame completes
    frame(60, -1, 20, 1'b0, 1'b0, 1'b0);
    send(1'b1, 8'hFB, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd7);
    frame(50, -1, -1, 1'b0, 1'b0, 1'b1);

    // Seventh preamble byte where SFD is required
    quiet(1'b1, 8'hFB);
    repeat (6) quiet(1'b0, 8'h55);
    send(1'b0, 8'h55, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd2);
    quiet(1'b1, 8'h07);

    // Unexpected control in payload, then START from DROP without a report
    frame(60, -1, 5, 1'b0, 1'b0, 1'b0);
    send(1'b1, 8'h1C, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd5);
    quiet(1'b1, 8'hFD);
    quiet(1'b1, 8'hFB);
    frame(48, -1, -1, 1'b0, 1'b0, 1'b1);

`ifdef MII_CHK_FCS_EN
    frame(46, -1, -1, 1'b1, 1'b0, 1'b0);
    frame(46, -1, -1, 1'b1, 1'b1, 1'b0);
    frame(45, -1, -1, 1'b0, 1'b1, 1'b0);
`endif

    // Randomized lengths
    for (int i = 0; i < 4; i++) frame($urandom_range(MINLEN, 120), -1, -1, 1'b0, 1'b0, 1'b0);

    // Reset mid-DATA clears everything asynchronously with no report
    frame(60, -1, 10, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #2;
    check_all_zero("midreset");
    good_n = 0;
    bad_n = 0;
    last_code = 3'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    quiet(1'b0, 8'($urandom));
    quiet(1'b1, 8'hFD);

    // Five good frames: the 2-bit counter stops at 3
    for (int i = 0; i < 5; i++) frame(MINLEN, -1, -1, 1'b0, 1'b0, 1'b0);
    chk("sat_good_final", s_good_cnt, 2'd3);
    chk("good_final", o_good_cnt, 16'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mii_frame_checker.md
Name: mii_frame_checker

Overview:
- Downstream consumer of the Ethernet frame generator's byte stream: one data byte plus control flag per clock.
- Parses each frame as START, preamble, SFD, payload, TERMINATE, and validates every field.
- Forwards payload bytes with frame delimiters and reports per-frame pass/fail with an error code.
- Keeps saturating good/bad frame counters for bench and on-chip loopback self-test.

Parameters:
- PREAMBLE_CYCLES, 6, number of 0x55 data bytes that must follow START.
- MIN_DATA_CYCLES, 46, minimum payload bytes between SFD and TERMINATE.
- MAX_DATA_CYCLES, 1500, maximum payload bytes.
- CNT_WIDTH, 16, width of the good/bad frame counters.
- IDLE_CODE, 8'h07, START_CODE, 8'hFB, PREAMBLE_CODE, 8'h55, SFD_CODE, 8'hD5, TERMINATE_CODE, 8'hFD: code values.

Ports:
- clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_rx_data  in  8  received byte, one per cycle, no valid qualifier.
- i_rx_ctrl  in  8  control qualifier; byte is a control character when i_rx_ctrl != 0.
- o_data  out  8  forwarded payload byte.
- o_data_valid  out  1  o_data holds a payload byte.
- o_sof  out  1  high with the first payload byte.
- o_eof  out  1  pulse on frame completion (good or bad).
- o_frame_ok  out  1  one-cycle pulse: frame passed all checks.
- o_frame_err  out  1  one-cycle pulse: frame failed.
- o_err_code  out  3  cause, valid while o_frame_err=1; holds its value until the next error.
- o_good_cnt  out  CNT_WIDTH  saturating good-frame count.
- o_bad_cnt  out  CNT_WIDTH  saturating bad-frame count.

Behaviour:
- Reset: all outputs 0, state IDLE, byte counters 0.
- All outputs are registered. A response appears 1 cycle after the input byte that causes it.
- Control byte ctl(X): i_rx_ctrl!=0 and i_rx_data==X. Data byte dat(X): i_rx_ctrl==0 and i_rx_data==X.
- States:
  - IDLE: ctl(START) -> PRE with count=0. Any other byte stays in IDLE with no report.
  - PRE: dat(PREAMBLE) increments count. Once PREAMBLE_CYCLES bytes are seen -> SFD. Any other byte -> error 1, go DROP.
  - SFD: dat(SFD) -> DATA with len=0. Any other byte -> error 2, go DROP.
  - DATA:
    - Data byte: forward it, len++. If len would exceed MAX_DATA_CYCLES -> error 4, go DROP; that byte is not forwarded.
    - ctl(TERMINATE): if len<MIN_DATA_CYCLES -> error 3; otherwise ok. Go IDLE.
    - Any other control byte (except START) -> error 5, go DROP.
  - DROP: discard bytes until ctl(IDLE) -> IDLE.
- ctl(START) in any state other than IDLE:
  - From PRE, SFD or DATA: report error 7 (aborted frame), then restart into PRE with count=0.
  - From DROP: restart into PRE with no additional report.
- Each frame produces exactly one report:
  - ok: o_frame_ok=1, o_eof=1, good_cnt++.
  - error: o_frame_err=1, o_eof=1, o_err_code set, bad_cnt++.
- Counters saturate at all-ones; they do not wrap.
- o_sof=1 with o_data_valid on the first forwarded byte of a frame only.
- Error codes: 1 bad preamble, 2 bad SFD, 3 short, 4 long, 5 unexpected control, 6 FCS mismatch, 7 aborted by START.
- i_rst asserted mid-frame clears the state immediately: no report, counters cleared.

Optional Feature:
- Macro MII_CHK_FCS_EN.
- Defined:
  - Compute CRC-32 (IEEE 802.3, reflected, init 0xFFFFFFFF) over all payload bytes, including the trailing 4 FCS bytes.
  - At TERMINATE, the residue must equal 0xC704DD7B.
  - Mismatch -> error 6. Error 3 takes priority over error 6.
  - FCS bytes are still forwarded on o_data.
- Undefined: no CRC logic is present, and error 6 never occurs.

Test Plan:
- Normal frame: IDLE x12, START, 6x dat(55), dat(D5), 46 data bytes 0..45, TERMINATE. Expect 46 o_data_valid beats with o_sof on byte 0, then o_frame_ok and o_eof 1 cycle after TERMINATE, good_cnt=1, bad_cnt=0.
- Bad preamble: 3rd preamble byte = dat(54). Expect o_frame_err with code 1, bad_cnt=1, and no o_data_valid. The following IDLE then a valid frame produces good_cnt=1.
- Short frame: 45 payload bytes then TERMINATE -> code 3. Payload of length 1501 -> code 4 at byte 1501, then DROP until IDLE.
- Abort: START arrives at payload byte 20 -> code 7. The new frame that follows completes ok, giving good_cnt=1, bad_cnt=1.
- Reset and saturation: i_rst pulsed mid-DATA clears all outputs and produces no report. With CNT_WIDTH=2, 5 good frames leave o_good_cnt=3.
- MII_CHK_FCS_EN: 46-byte payload with correct FCS -> ok. The same frame with 1 FCS bit flipped -> code 6.
